// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side logic.
// FRAME_BITS counts the bits driven after the start bit: 8 data, parity, stop.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SETUP,
        WAIT_START,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NOSTART = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_NOACK   = 2'd3;

    localparam int FRAME_BITS = 10;

    // Odd parity: the data byte plus this bit always holds an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchroniser, then a deglitch filter
// that only follows the synced level after FILTER_LEN consecutive equal samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The counter tracks how long sync2 has disagreed with the filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            fall  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                level <= sync2;
                fall  <= ~sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the bus, issues a request-to-send,
// then shifts data/parity/stop out on device clock falling edges and checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int SETUP_CYCLES   = 200,
    parameter int START_TIMEOUT  = 1500000,
    parameter int FRAME_TIMEOUT  = 200000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    // state      | meaning
    // IDLE       | lines released, ready for a byte
    // INHIBIT    | CLK pulled low to abort any device traffic
    // SETUP      | CLK and DATA low: request-to-send with start bit
    // WAIT_START | CLK released, waiting for the device's first falling edge
    // SEND       | driving data bits, parity and stop on falling edges
    // ACK        | sampling the device's ACK on the 11th falling edge
    // WAIT_IDLE  | waiting for the device to release both lines

    localparam int TMAX_A  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int TMAX    = (TMAX_A > START_TIMEOUT) ? TMAX_A : START_TIMEOUT;
    localparam int TIMER_W = $clog2(TMAX + 1);
    localparam int FRAME_W = $clog2(FRAME_TIMEOUT + 1);

    ps2_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic [FRAME_W-1:0] frame_cnt;
    logic [8:0]         shreg;
    logic [3:0]         bit_cnt;

    logic clk_filt;
    logic clk_fall;
    logic data_filt;
    logic data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_clk_in),
        .level (clk_filt),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_data_in),
        .level (data_filt),
        .fall  (data_fall_unused)
    );

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            frame_cnt   <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg       <= {1'b1, odd_parity(tx_data), tx_data};
                        bit_cnt     <= '0;
                        err_code    <= ERR_NONE;
                        timer       <= TIMER_W'(INHIBIT_CYCLES - 1);
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (timer == '0) begin
                        timer       <= TIMER_W'(SETUP_CYCLES - 1);
                        ps2_data_oe <= 1'b1;
                        state       <= SETUP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                SETUP: begin
                    if (timer == '0) begin
                        timer      <= TIMER_W'(START_TIMEOUT - 1);
                        ps2_clk_oe <= 1'b0;
                        state      <= WAIT_START;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                WAIT_START: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b1, shreg[8:1]};
                        bit_cnt     <= 4'd1;
                        frame_cnt   <= FRAME_W'(FRAME_TIMEOUT - 1);
                        state       <= SEND;
                    end else if (timer == '0) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        err_code    <= ERR_NOSTART;
                        state       <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                SEND, ACK, WAIT_IDLE: begin
                    // One frame budget covers data, ACK and the release of the lines.
                    if (frame_cnt == '0) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= IDLE;
                    end else begin
                        frame_cnt <= frame_cnt - 1'b1;
                        if (state == SEND) begin
                            if (clk_fall) begin
                                ps2_data_oe <= ~shreg[0];
                                shreg       <= {1'b1, shreg[8:1]};
                                bit_cnt     <= bit_cnt + 1'b1;
                                if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                                    state <= ACK;
                                end
                            end
                        end else if (state == ACK) begin
                            if (clk_fall) begin
                                if (!data_filt) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    ps2_clk_oe  <= 1'b0;
                                    ps2_data_oe <= 1'b0;
                                    done        <= 1'b1;
                                    err         <= 1'b1;
                                    err_code    <= ERR_NOACK;
                                    state       <= IDLE;
                                end
                            end
                        end else if (clk_filt && data_filt) begin
                            done     <= 1'b1;
                            err_code <= ERR_NONE;
                            state    <= IDLE;
                        end
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed/randomised bench for ps2_host_tx with an open-drain PS/2 device model;
// expected frames and timings are derived from the protocol rules, not the RTL.
module tb_ps2_host_tx;

    localparam int INH      = 10;
    localparam int SET      = 4;
    localparam int STO      = 300;
    localparam int FTO      = 3000;
    localparam int FLEN     = 2;
    localparam int HALF     = 20;
    // raw line edge -> 2 sync stages -> FLEN filter samples -> registered pulse
    localparam int EDGE_LAT = 2 + FLEN + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .START_TIMEOUT  (STO),
        .FRAME_TIMEOUT  (FTO),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int         n_pass  = 0;
    int         n_fail  = 0;
    int         n_total = 0;
    longint     cyc     = 0;
    int         done_cnt = 0;
    longint     done_cyc = 0;
    logic       done_err = 1'b0;
    logic [1:0] done_code = 2'd0;
    logic       done_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_err  <= err;
            done_code <= err_code;
            done_oe   <= ps2_clk_oe | ps2_data_oe;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected wire frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic request(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_release(output logic start_bit);
        int t;
        t = 0;
        while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
        t = 0;
        while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
        chk("clk_release", 64'(ps2_clk_oe), 64'd0);
        start_bit = ps2_data_in;
    endtask

    task automatic device_frame(input int n_clk, input bit ack,
                                output logic [10:0] samp, output longint t_fall1);
        logic sb;
        samp    = '1;
        t_fall1 = 0;
        wait_release(sb);
        samp[0] = sb;
        for (int i = 1; i <= n_clk; i++) begin
            if (i == 11) begin
                wait_n(HALF / 2);
                if (ack) dev_data = 1'b0;
                wait_n(HALF / 2);
            end else begin
                wait_n(HALF);
            end
            dev_clk = 1'b0;
            if (i == 1) t_fall1 = cyc;
            wait_n(HALF);
            dev_clk = 1'b1;
            if (i <= 10) samp[i] = ps2_data_in;
        end
        wait_n(5);
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input int start, input int budget, output bit got);
        int t;
        t = 0;
        while (done_cnt == start && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        got = (done_cnt != start);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] s;
        longint      tf, p;
        bit          got;
        int          start, t, n_inh, first_data;
        logic [7:0]  seq [6];
        logic        exp_par [3];
        logic [7:0]  b;
        logic        sb;

        // reset state
        wait_n(3);
        chk("rst_tx_ready", 64'(tx_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_oe", 64'({ps2_clk_oe, ps2_data_oe}), 64'd0);
        rst = 1'b0;
        wait_n(2);

        // 1: 0xED with ACK
        start = done_cnt;
        request(8'hED);
        chk("ready_drop", 64'(tx_ready), 64'd0);
        chk("busy_rise", 64'(busy), 64'd1);
        device_frame(11, 1'b1, s, tf);
        chk("frame_ED", 64'(s), 64'(frame_of(8'hED)));
        wait_done(start, 200, got);
        chk("ED_done_seen", 64'(got), 64'd1);
        chk("ED_err", 64'(done_err), 64'd0);
        chk("ED_err_code", 64'(done_code), 64'd0);
        chk("ED_lines_free", 64'(done_oe), 64'd0);
        @(negedge clk);
        chk("ED_ready_after", 64'(tx_ready), 64'd1);

        // 2: back-to-back frames, three directed plus three random bytes
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h01;
        for (int k = 3; k < 6; k++) seq[k] = 8'($urandom);
        exp_par[0] = 1'b1; exp_par[1] = 1'b1; exp_par[2] = 1'b0;
        p = longint'(done_cnt);
        for (int k = 0; k < 6; k++) begin
            start = done_cnt;
            request(seq[k]);
            device_frame(11, 1'b1, s, tf);
            chk($sformatf("frame_%02h", seq[k]), 64'(s), 64'(frame_of(seq[k])));
            if (k < 3) chk($sformatf("parity_%02h", seq[k]), 64'(s[9]), 64'(exp_par[k]));
            wait_done(start, 200, got);
            chk("b2b_done_seen", 64'(got), 64'd1);
            chk("b2b_err", 64'(done_err), 64'd0);
        end
        chk("b2b_done_count", 64'(longint'(done_cnt) - p), 64'd6);

        // 3: device never clocks
        start = done_cnt;
        p = cyc;
        request(8'($urandom));
        n_inh = 0;
        first_data = -1;
        for (t = 0; t < 20; t++) begin
            if (ps2_clk_oe && !ps2_data_oe) n_inh++;
            if (ps2_data_oe && first_data < 0) first_data = t;
            @(negedge clk);
        end
        chk("inhibit_len", 64'(n_inh), 64'(INH));
        chk("start_bit_at", 64'(first_data), 64'(INH));
        wait_done(start, 400, got);
        chk("nostart_done_seen", 64'(got), 64'd1);
        chk("nostart_err", 64'(done_err), 64'd1);
        chk("nostart_code", 64'(done_code), 64'd1);
        chk("nostart_lines", 64'(done_oe), 64'd0);
        chk("nostart_time", 64'(done_cyc - p), 64'(INH + SET + STO + 1));

        // 4: device stops after five clocks
        start = done_cnt;
        request(8'($urandom));
        device_frame(5, 1'b0, s, tf);
        wait_done(start, FTO + 200, got);
        chk("tmo_done_seen", 64'(got), 64'd1);
        chk("tmo_err", 64'(done_err), 64'd1);
        chk("tmo_code", 64'(done_code), 64'd2);
        chk("tmo_lines", 64'(done_oe), 64'd0);
        chk("tmo_time", 64'(done_cyc - tf), 64'(FTO + EDGE_LAT));

        // 5: no ACK from device
        start = done_cnt;
        b = 8'($urandom);
        request(b);
        device_frame(11, 1'b0, s, tf);
        chk("noack_frame", 64'(s), 64'(frame_of(b)));
        wait_done(start, 100, got);
        chk("noack_done_seen", 64'(got), 64'd1);
        chk("noack_err", 64'(done_err), 64'd1);
        chk("noack_code", 64'(done_code), 64'd3);
        chk("noack_lines", 64'(done_oe), 64'd0);

        // 6: ignored tx_valid during SEND, then reset mid-frame
        start = done_cnt;
        request(8'hA3);
        wait_release(sb);
        s = '1;
        s[0] = sb;
        for (int i = 1; i <= 4; i++) begin
            wait_n(HALF);
            dev_clk = 1'b0;
            wait_n(HALF);
            dev_clk = 1'b1;
            s[i] = ps2_data_in;
            if (i == 2) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                chk("busy_ignore_ready", 64'(tx_ready), 64'd0);
                chk("busy_ignore_busy", 64'(busy), 64'd1);
            end
        end
        chk("abort_bits", 64'(s[4:0]), 64'(frame_of(8'hA3) & 11'h01F));
        wait_n(HALF);
        dev_clk = 1'b0;
        wait_n(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_oe", 64'({ps2_clk_oe, ps2_data_oe}), 64'd0);
        chk("rst_mid_ready", 64'(tx_ready), 64'd1);
        chk("rst_mid_code", 64'(err_code), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        wait_n(10);
        dev_clk = 1'b1;
        wait_n(50);
        chk("rst_no_done", 64'(done_cnt - start), 64'd0);
        chk("rst_stays_idle", 64'({tx_ready, ps2_clk_oe}), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
